// File: rtl/sha256_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sha256_pkg                                                  |
// | Brief  : SHA-256 round constants, initial hash values, the bitwise   |
// |          round/schedule functions and the core state encoding.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Initial hash word i for the selected digest flavour (1 = SHA-224)
  function automatic logic [31:0] iv_word(input int i, input logic is224);
    return is224 ? IV224[i] : IV256[i];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sha256_round                                                |
// | Brief  : One combinational SHA-256 compression round.                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] a_nxt,
  output logic [31:0] b_nxt,
  output logic [31:0] c_nxt,
  output logic [31:0] d_nxt,
  output logic [31:0] e_nxt,
  output logic [31:0] f_nxt,
  output logic [31:0] g_nxt,
  output logic [31:0] h_nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  // Standard round: two temporaries, then rotate the working variables
  always_comb begin
    t1    = h + Sigma1(e) + ch(e, f, g) + k + w;
    t2    = Sigma0(a) + maj(a, b, c);
    a_nxt = t1 + t2;
    b_nxt = a;
    c_nxt = b;
    d_nxt = c;
    e_nxt = d + t1;
    f_nxt = e;
    g_nxt = f;
    h_nxt = g;
  end

endmodule
`default_nettype wire

// File: rtl/sha256_stream_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sha256_stream_core                                          |
// | Brief  : Multi-block SHA-256 engine, valid/ready block input and     |
// |          digest output, UNROLL rounds per clock, chained H state.    |
// |          Define SHA224_EN to add the mode_224 port (SHA-224 digest). |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int UNROLL   = 1,
  parameter int PIPE_OUT = 1
)
(
  input  logic         clk,
  input  logic         clr,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA224_EN
  input  logic         mode_224,
`endif
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy
);

  localparam int         NCYC     = 64 / UNROLL;
  localparam logic [5:0] LAST_RND = 6'(NCYC - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  rnd;
  logic [31:0] win   [0:15];
  logic [31:0] var_q [0:7];
  logic [31:0] h_q   [0:7];
  logic        msg_open;
  logic        from_iv;
  logic        last_q;

  logic        accept;
  logic        fresh;
  logic        mode_q;
  logic        mode_new;
  logic [31:0] ext   [0:15+UNROLL];
  logic [31:0] chain [0:UNROLL][0:7];
  logic [31:0] h_sum [0:7];
  logic [255:0] digest_fmt;

  assign accept    = blk_valid & blk_ready;
  assign blk_ready = (state == IDLE) & ~digest_valid;
  assign busy      = (state != IDLE);
  // A block with no open chain starts a new message whatever blk_first says
  assign fresh     = blk_first | ~msg_open;

`ifdef SHA224_EN
  assign mode_new = fresh ? mode_224 : mode_q;

  // Digest flavour is captured with the first block and held for the message
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      mode_q <= 1'b0;
    else if (accept && fresh)
      mode_q <= mode_224;
  end
`else
  assign mode_q   = 1'b0;
  assign mode_new = 1'b0;
`endif

  // Message schedule: extend the 16-word window by UNROLL words per cycle
  for (genvar i = 0; i < 16; i++) begin : g_win
    assign ext[i] = win[i];
  end
  for (genvar j = 0; j < UNROLL; j++) begin : g_sched
    assign ext[16+j] = sigma1(ext[14+j]) + ext[9+j] + sigma0(ext[1+j]) + ext[j];
  end

  // Round chain: UNROLL rounds applied back to back each clock
  for (genvar i = 0; i < 8; i++) begin : g_chain0
    assign chain[0][i] = var_q[i];
  end
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [5:0] kidx;
    assign kidx = 6'(int'(rnd) * UNROLL + j);
    sha256_round u_round (
      .a     (chain[j][0]),   .b     (chain[j][1]),
      .c     (chain[j][2]),   .d     (chain[j][3]),
      .e     (chain[j][4]),   .f     (chain[j][5]),
      .g     (chain[j][6]),   .h     (chain[j][7]),
      .k     (K[kidx]),       .w     (ext[j]),
      .a_nxt (chain[j+1][0]), .b_nxt (chain[j+1][1]),
      .c_nxt (chain[j+1][2]), .d_nxt (chain[j+1][3]),
      .e_nxt (chain[j+1][4]), .f_nxt (chain[j+1][5]),
      .g_nxt (chain[j+1][6]), .h_nxt (chain[j+1][7])
    );
  end

  // Chaining-value update: add the block result onto IV or the previous H
  always_comb begin
    for (int i = 0; i < 8; i++)
      h_sum[i] = (from_iv ? iv_word(i, mode_q) : h_q[i]) + var_q[i];
  end

  // Pack H0..H7 MSB-first; SHA-224 drops H7
  always_comb begin
    for (int i = 0; i < 8; i++)
      digest_fmt[255-32*i -: 32] = h_q[i];
    if (mode_q)
      digest_fmt[31:0] = 32'h0;
  end

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (rnd == LAST_RND) state_nxt = FINAL;
      FINAL:   state_nxt = last_q ? OUT : IDLE;
      OUT:     if (digest_valid && digest_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Block intake, round iteration and H update
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rnd      <= 6'd0;
      msg_open <= 1'b0;
      from_iv  <= 1'b0;
      last_q   <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= 32'h0;
      for (int i = 0; i < 8; i++) begin
        var_q[i] <= 32'h0;
        h_q[i]   <= 32'h0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rnd     <= 6'd0;
            from_iv <= fresh;
            last_q  <= blk_last;
            for (int i = 0; i < 16; i++) win[i] <= blk_data[511-32*i -: 32];
            for (int i = 0; i < 8; i++)
              var_q[i] <= fresh ? iv_word(i, mode_new) : h_q[i];
          end
        end
        ROUND: begin
          rnd <= (rnd == LAST_RND) ? 6'd0 : rnd + 6'd1;
          for (int i = 0; i < 16; i++) win[i] <= ext[i+UNROLL];
          for (int i = 0; i < 8; i++) var_q[i] <= chain[UNROLL][i];
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_sum[i];
          msg_open <= ~last_q;
        end
        default: ;
      endcase
    end
  end

  if (PIPE_OUT != 0) begin : g_pipe
    logic [255:0] dig_q;
    logic         dv_q;

    // Output stage: capture the digest on the first OUT cycle, hold until taken
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        dig_q <= 256'h0;
        dv_q  <= 1'b0;
      end else if (state == OUT) begin
        if (!dv_q) begin
          dig_q <= digest_fmt;
          dv_q  <= 1'b1;
        end else if (digest_ready) begin
          dv_q  <= 1'b0;
        end
      end
    end

    assign digest       = dig_q;
    assign digest_valid = dv_q;
  end else begin : g_direct
    assign digest       = digest_fmt;
    assign digest_valid = (state == OUT);
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_stream_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_sha256_stream_core                                       |
// | Brief  : Directed self-checking bench for sha256_stream_core using   |
// |          known SHA-256 vectors (UNROLL=1 and UNROLL=4 instances).    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_sha256_stream_core;

  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

  localparam int LAT_A = 66;
  localparam int LAT_B = 18;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [511:0] data = '0;
  logic         first = 1'b0;
  logic         last = 1'b0;
  logic         mode = 1'b0;
  logic         valid_a = 1'b0, valid_b = 1'b0;
  logic         dr_a = 1'b0, dr_b = 1'b0;
  logic         rdy_a, rdy_b, dv_a, dv_b, busy_a, busy_b;
  logic [255:0] dig_a, dig_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_stream_core #(.UNROLL(1), .PIPE_OUT(1)) dut_a (
    .clk(clk), .clr(clr), .blk_valid(valid_a), .blk_ready(rdy_a),
    .blk_data(data), .blk_first(first), .blk_last(last),
`ifdef SHA224_EN
    .mode_224(mode),
`endif
    .digest(dig_a), .digest_valid(dv_a), .digest_ready(dr_a), .busy(busy_a)
  );

  sha256_stream_core #(.UNROLL(4), .PIPE_OUT(1)) dut_b (
    .clk(clk), .clr(clr), .blk_valid(valid_b), .blk_ready(rdy_b),
    .blk_data(data), .blk_first(first), .blk_last(last),
`ifdef SHA224_EN
    .mode_224(mode),
`endif
    .digest(dig_b), .digest_valid(dv_b), .digest_ready(dr_b), .busy(busy_b)
  );

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl [0:8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer a block to instance A and complete the accept edge
  task automatic send_a(input logic [511:0] d, input logic f, input logic l);
    int n;
    n = 0;
    while (!rdy_a && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("blk_ready_before_send", 256'(rdy_a), 256'(1));
    data = d; first = f; last = l; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    // Scramble the bus afterwards: the core must ignore it outside accept edges
    data  = {16{$urandom}};
    first = 1'($urandom);
    last  = 1'($urandom);
    check("busy_after_accept", 256'(busy_a), 256'(1));
  endtask

  // Count edges from accept until digest_valid rises on A
  task automatic wait_digest_a(input logic [255:0] exp);
    int lat;
    lat = 0;
    while (!dv_a && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    check("latency_a", 256'(lat), 256'(LAT_A));
    check("digest_a", dig_a, exp);
  endtask

  task automatic take_digest_a;
    dr_a = 1'b1;
    @(posedge clk); #1;
    dr_a = 1'b0;
    check("digest_valid_drop", 256'(dv_a), 256'(0));
    check("blk_ready_after_take", 256'(rdy_a), 256'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int la, lb;
    logic ok;

    tbl[0] = '{BLK_EMPTY, 1'b1, 1'b1, D_EMPTY};
    tbl[1] = '{BLK_ABC,   1'b1, 1'b1, D_ABC};
    tbl[2] = '{BLK_TWO1,  1'b1, 1'b0, '0};
    tbl[3] = '{BLK_TWO2,  1'b0, 1'b1, D_TWO};
    tbl[4] = '{BLK_ABC,   1'b0, 1'b1, D_ABC};   // closed chain: treated as first
    tbl[5] = '{BLK_TWO1,  1'b1, 1'b0, '0};
    tbl[6] = '{BLK_ABC,   1'b1, 1'b1, D_ABC};   // restart while chain open
    tbl[7] = '{BLK_TWO1,  1'b0, 1'b0, '0};      // closed chain: treated as first
    tbl[8] = '{BLK_TWO2,  1'b0, 1'b1, D_TWO};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_digest_valid_a", 256'(dv_a), 256'(0));
    check("reset_digest_a", dig_a, 256'h0);
    check("reset_busy_a", 256'(busy_a), 256'(0));
    check("reset_digest_valid_b", 256'(dv_b), 256'(0));
    check("reset_busy_b", 256'(busy_b), 256'(0));
    clr = 1'b1;
    @(posedge clk); #1;
    check("post_reset_blk_ready", 256'(rdy_a), 256'(1));

    // Table of messages on instance A
    for (int i = 0; i < 9; i++) begin
      send_a(tbl[i].data, tbl[i].first, tbl[i].last);
      if (tbl[i].last) begin
        wait_digest_a(tbl[i].exp);
        if (i == 1) begin
          // Back-pressure: digest must hold and no new block may be taken
          ok = 1'b1;
          for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!dv_a || rdy_a || dig_a !== tbl[i].exp) ok = 1'b0;
          end
          check("hold_digest_stable", 256'(ok), 256'(1));
        end
        take_digest_a();
      end
    end

    // UNROLL=1 vs UNROLL=4 latency on the same block
    check("b_idle", 256'(rdy_b), 256'(1));
    data = BLK_ABC; first = 1'b1; last = 1'b1;
    valid_a = 1'b1; valid_b = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    la = -1; lb = -1;
    for (int n = 1; n <= 100 && (la < 0 || lb < 0); n++) begin
      @(posedge clk); #1;
      if (dv_a && la < 0) la = n;
      if (dv_b && lb < 0) lb = n;
    end
    check("latency_u1", 256'(la), 256'(LAT_A));
    check("latency_u4", 256'(lb), 256'(LAT_B));
    check("digest_u1", dig_a, D_ABC);
    check("digest_u4", dig_b, D_ABC);
    dr_a = 1'b1; dr_b = 1'b1;
    @(posedge clk); #1;
    dr_a = 1'b0; dr_b = 1'b0;
    check("drop_u4", 256'(dv_b), 256'(0));

    // Asynchronous reset in the middle of block 1 of a two-block message
    send_a(BLK_TWO1, 1'b1, 1'b0);
    repeat (29) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("abort_busy", 256'(busy_a), 256'(0));
    check("abort_digest_valid", 256'(dv_a), 256'(0));
    @(posedge clk); #1;
    clr = 1'b1;
    send_a(BLK_ABC, 1'b0, 1'b1);
    wait_digest_a(D_ABC);
    take_digest_a();

`ifdef SHA224_EN
    mode = 1'b1;
    send_a(BLK_ABC, 1'b1, 1'b1);
    wait_digest_a(D_ABC224);
    take_digest_a();
    mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
